// File: rtl/icon_channel_sched_if.sv
// Shared interconnect types and the bundled order/source/receiver port set of
// one broadcast-channel sequencer.
package icon_pkg;
    localparam int LOG2_NUM_EXEC_UNITS = 2;
    localparam int NUM_EU              = 2 ** LOG2_NUM_EXEC_UNITS;
    localparam int DATA_W              = 16;
    localparam int REGIDX_W            = 6;

    typedef struct packed {
        logic [LOG2_NUM_EXEC_UNITS-1:0] euidx;
        logic [REGIDX_W-1:0]            regidx;
    } type_exec_unit_addr;

    typedef logic [DATA_W-1:0] type_exec_unit_data;

    // Execution units occupy the low bits so that eus[i] is receiver bit i.
    typedef struct packed {
        logic [1:0]        ext;
        logic [NUM_EU-1:0] lsu;
        logic [NUM_EU-1:0] eus;
    } type_icon_receivers_list;

    typedef struct packed {
        type_exec_unit_addr      src_addr;
        type_icon_receivers_list receiver_list;
    } type_icon_instr;

    typedef struct packed {
        logic                    data_valid;
        type_exec_unit_data      data;
        type_exec_unit_addr      src_addr;
        type_icon_receivers_list receiver_list;
        type_icon_receivers_list success_list;
    } type_icon_channel;
endpackage

interface icon_channel_sched_if;
    import icon_pkg::*;

    logic                                instr_valid_i;
    type_icon_instr                      instr_i;
    logic                                instr_ready_o;
    logic [NUM_EU-1:0]                   src_req_o;
    type_exec_unit_addr                  src_addr_o;
    logic [NUM_EU-1:0]                   src_valid_i;
    type_exec_unit_data [NUM_EU-1:0]     src_data_i;
    type_icon_receivers_list             success_i;
    type_icon_channel                    channel_o;
    logic                                busy_o;
    logic                                err_timeout_o;

    // The sequencer itself.
    modport slave (
        input  instr_valid_i, instr_i, src_valid_i, src_data_i, success_i,
        output instr_ready_o, src_req_o, src_addr_o, channel_o, busy_o, err_timeout_o
    );

    // Front end, source EUs and receivers around the sequencer.
    modport master (
        output instr_valid_i, instr_i, src_valid_i, src_data_i, success_i,
        input  instr_ready_o, src_req_o, src_addr_o, channel_o, busy_o, err_timeout_o
    );
endinterface

// File: rtl/icon_channel_sched.sv
// Per-channel sequencer: queues transfer orders, reads the operand from the
// source EU, then broadcasts it until every listed receiver has captured it.
module icon_channel_sched
    import icon_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    icon_channel_sched_if.slave   bus
);

    localparam int NRX   = $bits(type_icon_receivers_list);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_BCAST  = 2'd2,
        S_RETIRE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    type_icon_instr     mem_q [FIFO_DEPTH];
    type_icon_instr     mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    type_icon_instr     cur_q, cur_d;
    type_exec_unit_data data_q, data_d;
    logic [NRX-1:0]     acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic                           full;
    logic                           empty;
    logic                           push;
    logic                           pop;
    logic [LOG2_NUM_EXEC_UNITS-1:0] eu;
    logic [NRX-1:0]                 mask;
    logic [NRX-1:0]                 acc_nxt;
    logic                           done;

    assign full    = (count_q == FIFO_FULL);
    assign empty   = (count_q == '0);
    // Ready depends on the registered count only, so a same-cycle pop never frees a slot.
    assign push    = bus.instr_valid_i && !full;
    assign pop     = (state_q == S_IDLE) && !empty;
    assign eu      = cur_q.src_addr.euidx;
    assign mask    = cur_q.receiver_list;
    assign acc_nxt = acc_q | (bus.success_i & mask);
    assign done    = (acc_nxt == mask);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = bus.instr_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d           = state_q;
        cur_d             = cur_q;
        data_d            = data_q;
        acc_d             = acc_q;
        cnt_d             = cnt_q;
        bus.src_req_o     = '0;
        bus.src_addr_o    = '0;
        bus.channel_o     = '0;
        bus.err_timeout_o = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    cur_d = mem_q[rd_ptr_q];
                    // An order with no receivers is consumed without touching the source.
                    if (mem_q[rd_ptr_q].receiver_list != '0) begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                bus.src_req_o  = NUM_EU'(1) << eu;
                bus.src_addr_o = cur_q.src_addr;
                if (bus.src_valid_i[eu]) begin
                    data_d  = bus.src_data_i[eu];
                    state_d = S_BCAST;
                end
            end
            S_BCAST: begin
                bus.channel_o.data_valid    = 1'b1;
                bus.channel_o.data          = data_q;
                bus.channel_o.src_addr      = cur_q.src_addr;
                bus.channel_o.receiver_list = cur_q.receiver_list;
                bus.channel_o.success_list  = acc_q;
                if (done) begin
                    acc_d   = acc_nxt;
                    state_d = S_RETIRE;
                end else if (cnt_q == CNT_LAST) begin
                    bus.err_timeout_o = 1'b1;
                    state_d           = S_RETIRE;
                end else begin
                    acc_d = acc_nxt;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RETIRE: begin
                acc_d   = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.instr_ready_o = !full;
    assign bus.busy_o        = (state_q != S_IDLE) || !empty;

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cur_q    <= '0;
            data_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cur_q    <= cur_d;
            data_q   <= data_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: tb/tb_icon_channel_sched.sv
// Directed bench for icon_channel_sched with an order-level reference model
// compared against the outputs every cycle.
module tb_icon_channel_sched;
    import icon_pkg::*;

    localparam int D = 4;
    localparam int T = 8;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    icon_channel_sched_if bus ();

    icon_channel_sched #(.FIFO_DEPTH(D), .TIMEOUT_CYCLES(T)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic type_icon_instr mk(input int eu, input int rg, input logic [9:0] m);
        type_icon_instr o;
        o.src_addr.euidx  = eu[1:0];
        o.src_addr.regidx = rg[5:0];
        o.receiver_list   = m;
        return o;
    endfunction

    // Reference model: a plain queue of orders plus the phase of the order in flight
    // (0 waiting, 1 fetching operand, 2 broadcasting, 3 retiring).
    type_icon_instr     mq [$];
    type_exec_unit_addr m_log [$];
    int                 m_phase = 0;
    type_icon_instr     m_cur;
    type_exec_unit_data m_data;
    logic [9:0]         m_acc;
    int                 m_bcyc;
    int                 m_err_cnt = 0;
    bit                 m_on = 1'b0;
    int                 m_size;
    type_icon_instr     m_pop;
    logic [9:0]         m_nacc;
    logic [9:0]         m_mask;
    logic [3:0]         e_req;
    type_exec_unit_addr e_addr;
    type_icon_channel   e_ch;
    logic               e_err;

    always @(negedge clk) begin
        m_mask = m_cur.receiver_list;
        m_nacc = m_acc | (bus.success_i & m_mask);
        if (m_on) begin
            e_req  = (m_phase == 1) ? (4'b0001 << m_cur.src_addr.euidx) : 4'b0000;
            e_addr = (m_phase == 1) ? m_cur.src_addr : '0;
            e_ch   = '0;
            if (m_phase == 2) begin
                e_ch.data_valid    = 1'b1;
                e_ch.data          = m_data;
                e_ch.src_addr      = m_cur.src_addr;
                e_ch.receiver_list = m_cur.receiver_list;
                e_ch.success_list  = m_acc;
            end
            e_err = (m_phase == 2) && (m_bcyc == T) && (m_nacc != m_mask);
            if (e_err) m_err_cnt++;
            chk("m_ready",   64'(bus.instr_ready_o), 64'(mq.size() < D));
            chk("m_busy",    64'(bus.busy_o), 64'((m_phase != 0) || (mq.size() != 0)));
            chk("m_src_req", 64'(bus.src_req_o), 64'(e_req));
            chk("m_src_addr", 64'(bus.src_addr_o), 64'(e_addr));
            chk("m_channel", 64'(bus.channel_o), 64'(e_ch));
            chk("m_err",     64'(bus.err_timeout_o), 64'(e_err));
        end
        if (reset) begin
            mq.delete();
            m_phase = 0;
            m_acc   = '0;
            m_bcyc  = 0;
            m_cur   = '0;
            m_data  = '0;
            m_on    = 1'b1;
        end else if (m_on) begin
            m_size = mq.size();
            case (m_phase)
                0: if (m_size > 0) begin
                    m_pop = mq.pop_front();
                    if (m_pop.receiver_list != '0) begin
                        m_cur   = m_pop;
                        m_phase = 1;
                    end
                end
                1: if (bus.src_valid_i[m_cur.src_addr.euidx]) begin
                    m_data  = bus.src_data_i[m_cur.src_addr.euidx];
                    m_acc   = '0;
                    m_bcyc  = 1;
                    m_phase = 2;
                    m_log.push_back(m_cur.src_addr);
                end
                2: if (m_nacc == m_mask || m_bcyc == T) begin
                    m_phase = 3;
                end else begin
                    m_acc = m_nacc;
                    m_bcyc++;
                end
                default: m_phase = 0;
            endcase
            if (bus.instr_valid_i && m_size < D) mq.push_back(bus.instr_i);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.instr_valid_i = 1'b0;
        bus.instr_i       = '0;
        bus.src_valid_i   = '0;
        bus.src_data_i    = '0;
        bus.success_i     = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit hit;
        drive_idle();
        // Reset while an order is offered: nothing may be enqueued.
        reset             = 1'b1;
        bus.instr_valid_i = 1'b1;
        bus.instr_i       = mk(3, 1, 10'h3FF);
        tick();
        tick();
        reset             = 1'b0;
        bus.instr_valid_i = 1'b0;
        look();
        chk("rst_ready",   64'(bus.instr_ready_o), 64'd1);
        chk("rst_busy",    64'(bus.busy_o), 64'd0);
        chk("rst_channel", 64'(bus.channel_o), 64'd0);
        chk("rst_src_req", 64'(bus.src_req_o), 64'd0);
        chk("rst_err",     64'(bus.err_timeout_o), 64'd0);
        tick();

        // Best-case latency: euidx 1, receivers eus[2]|eus[3], operand 0xA5.
        bus.instr_valid_i = 1'b1;
        bus.instr_i       = mk(1, 5, 10'h00C);
        look();
        chk("t2_ready", 64'(bus.instr_ready_o), 64'd1);
        tick();
        bus.instr_valid_i = 1'b0;
        look();
        chk("t2_pop_noreq", 64'(bus.src_req_o), 64'd0);
        tick();
        bus.src_valid_i   = 4'b0010;
        bus.src_data_i[1] = 16'h00A5;
        look();
        chk("t2_req",  64'(bus.src_req_o), 64'h2);
        chk("t2_addr", 64'(bus.src_addr_o), 64'h45);
        tick();
        bus.src_valid_i = '0;
        bus.success_i   = 10'h00C;
        look();
        chk("t2_dv",   64'(bus.channel_o.data_valid), 64'd1);
        chk("t2_data", 64'(bus.channel_o.data), 64'hA5);
        tick();
        bus.success_i = '0;
        look();
        chk("t2_retire_dv",   64'(bus.channel_o.data_valid), 64'd0);
        chk("t2_retire_busy", 64'(bus.busy_o), 64'd1);
        tick();
        look();
        chk("t2_idle_busy", 64'(bus.busy_o), 64'd0);
        tick();

        // Successes spread over the broadcast: eus[2] in cycle 1, eus[3] in cycle 4.
        bus.instr_valid_i = 1'b1;
        bus.instr_i       = mk(1, 6, 10'h00C);
        tick();
        bus.instr_valid_i = 1'b0;
        tick();
        bus.src_valid_i   = 4'b0010;
        bus.src_data_i[1] = 16'h1234;
        look();
        chk("t3_req", 64'(bus.src_req_o), 64'h2);
        tick();
        bus.src_valid_i = '0;
        bus.success_i   = 10'h004;
        look();
        chk("t3_succ_c1", 64'(bus.channel_o.success_list), 64'h0);
        tick();
        bus.success_i = '0;
        look();
        chk("t3_succ_c2", 64'(bus.channel_o.success_list), 64'h4);
        tick();
        look();
        chk("t3_dv_c3", 64'(bus.channel_o.data_valid), 64'd1);
        tick();
        bus.success_i = 10'h008;
        look();
        chk("t3_err_c4", 64'(bus.err_timeout_o), 64'd0);
        chk("t3_dv_c4",  64'(bus.channel_o.data_valid), 64'd1);
        tick();
        bus.success_i = '0;
        look();
        chk("t3_retire_dv", 64'(bus.channel_o.data_valid), 64'd0);
        tick();

        // First order stalls in REQ while five more are offered back-to-back.
        m_log.delete();
        bus.instr_valid_i = 1'b1;
        bus.instr_i       = mk(0, 1, 10'h001);
        tick();
        bus.instr_valid_i = 1'b0;
        tick();
        look();
        chk("t4_stall_req", 64'(bus.src_req_o), 64'h1);
        tick();
        for (int i = 1; i <= 5; i++) begin
            bus.instr_valid_i = 1'b1;
            bus.instr_i       = mk(i % 4, 10 + i, 10'h200 | (10'h001 << (i - 1)));
            look();
            chk("t4_ready", 64'(bus.instr_ready_o), 64'(i < 5));
            tick();
        end
        bus.instr_valid_i = 1'b0;
        bus.src_valid_i   = 4'hF;
        bus.src_data_i    = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        bus.success_i     = 10'h3FF;
        hit = 1'b0;
        for (int c = 0; c < 60; c++) begin
            look();
            if (!bus.busy_o) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        chk("t4_drain", 64'(hit), 64'd1);
        tick();
        drive_idle();
        chk("t4_log_n", 64'(m_log.size()), 64'd5);
        if (m_log.size() == 5) begin
            chk("t4_log0", 64'(m_log[0]), 64'h01);
            chk("t4_log1", 64'(m_log[1]), 64'h4B);
            chk("t4_log2", 64'(m_log[2]), 64'h8C);
            chk("t4_log3", 64'(m_log[3]), 64'hCD);
            chk("t4_log4", 64'(m_log[4]), 64'h0E);
        end

        // Timeout: receiver never answers; a second order waits behind it.
        m_err_cnt         = 0;
        bus.instr_valid_i = 1'b1;
        bus.instr_i       = mk(2, 3, 10'h001);
        tick();
        bus.instr_i       = mk(3, 4, 10'h002);
        tick();
        bus.instr_valid_i = 1'b0;
        bus.src_valid_i   = 4'b0100;
        bus.src_data_i[2] = 16'hBEEF;
        hit = 1'b0;
        for (int c = 0; c < 10; c++) begin
            look();
            if (bus.src_req_o != '0) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        chk("t5_req_seen", 64'(hit), 64'd1);
        tick();
        bus.src_valid_i = '0;
        for (int k = 1; k <= T; k++) begin
            look();
            chk("t5_err", 64'(bus.err_timeout_o), 64'(k == T));
            chk("t5_dv",  64'(bus.channel_o.data_valid), 64'd1);
            tick();
        end
        look();
        chk("t5_retire_err", 64'(bus.err_timeout_o), 64'd0);
        chk("t5_model_errs", 64'(m_err_cnt), 64'd1);
        tick();
        bus.src_valid_i   = 4'b1000;
        bus.src_data_i[3] = 16'h0C0D;
        bus.success_i     = 10'h002;
        hit = 1'b0;
        for (int c = 0; c < 10; c++) begin
            look();
            if (bus.channel_o.data_valid) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        chk("t5_next_bcast", 64'(hit), 64'd1);
        chk("t5_next_addr",  64'(bus.channel_o.src_addr), 64'hC4);
        chk("t5_next_data",  64'(bus.channel_o.data), 64'h0C0D);
        tick();
        drive_idle();
        tick();
        tick();

        // Empty-mask order is dropped; the following order is then reset mid-broadcast.
        bus.instr_valid_i = 1'b1;
        bus.instr_i       = mk(1, 7, 10'h000);
        tick();
        bus.instr_i = mk(2, 8, 10'h010);
        look();
        chk("t6_req_c1", 64'(bus.src_req_o), 64'd0);
        tick();
        bus.instr_valid_i = 1'b0;
        look();
        chk("t6_req_c2", 64'(bus.src_req_o), 64'd0);
        tick();
        bus.src_valid_i   = 4'b0100;
        bus.src_data_i[2] = 16'h0077;
        look();
        chk("t6_req_c3", 64'(bus.src_req_o), 64'h4);
        tick();
        bus.src_valid_i = '0;
        reset           = 1'b1;
        look();
        chk("t6_bcast_dv",   64'(bus.channel_o.data_valid), 64'd1);
        chk("t6_bcast_addr", 64'(bus.channel_o.src_addr), 64'h88);
        chk("t6_bcast_err",  64'(bus.err_timeout_o), 64'd0);
        tick();
        reset = 1'b0;
        look();
        chk("t6_rst_channel", 64'(bus.channel_o), 64'd0);
        chk("t6_rst_busy",    64'(bus.busy_o), 64'd0);
        chk("t6_rst_err",     64'(bus.err_timeout_o), 64'd0);
        chk("t6_rst_ready",   64'(bus.instr_ready_o), 64'd1);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/icon_channel_sched.md
# icon_channel_sched

Sequencer for one interconnect broadcast channel. Queues `type_icon_instr` transfer orders from the front end and fetches the operand from the source execution unit named by `src_addr.euidx`. It then drives a `type_icon_channel` until every receiver in the order's `receiver_list` has reported success, and retires the order. One instance sits per channel between the dispatch stage and the interconnect fabric.

## Interface
- `FIFO_DEPTH`, 4: order queue depth; power of two, ≥2.
- `TIMEOUT_CYCLES`, 64: maximum cycles spent in BCAST before forced retire; ≥1.
- Derived: `NUM_EU` = 2**`LOG2_NUM_EXEC_UNITS`; `NRX` = `$bits(type_icon_receivers_list)` = 2·`NUM_EU`+2.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `instr_valid_i`  in  1  order offered.
- `instr_i`  in  `type_icon_instr`  order: source address plus receiver mask.
- `instr_ready_o`  out  1  queue not full; order accepted when valid&&ready.
- `src_req_o`  out  `NUM_EU`  one-hot read request to the source EU.
- `src_addr_o`  out  `type_exec_unit_addr`  address being read.
- `src_valid_i`  in  `NUM_EU`  per-EU data-valid response.
- `src_data_i`  in  `NUM_EU`×`type_exec_unit_data`  per-EU read data.
- `success_i`  in  `type_icon_receivers_list`  per-receiver capture strobe.
- `channel_o`  out  `type_icon_channel`  broadcast channel.
- `busy_o`  out  1  FSM not IDLE or queue non-empty.
- `err_timeout_o`  out  1  one-cycle pulse on forced retire.

## Operation
- Queue: circular FIFO with registered write. Push on `instr_valid_i && instr_ready_o`. `instr_ready_o` = !full, and is never relaxed by a same-cycle pop. Pointers wrap modulo `FIFO_DEPTH`. The count is 0..`FIFO_DEPTH`.
- State machine has four states: IDLE, REQ, BCAST, RETIRE.
- IDLE: if the queue is non-empty, pop the head into `cur` (src_addr, mask).
  - Mask == 0: discard the order and stay in IDLE.
  - Otherwise go to REQ.
- REQ:
  - `src_req_o` = onehot(`cur.src_addr.euidx`); `src_addr_o` = `cur.src_addr`.
  - When `src_valid_i[euidx]` is high, latch `src_data_i[euidx]` into `data_q` and go to BCAST.
  - No timeout in REQ.
- BCAST:
  - `channel_o.data_valid` = 1, `channel_o.data` = `data_q`, `channel_o.src_addr` = `cur.src_addr`, `channel_o.receiver_list` = mask, `channel_o.success_list` = `acc`.
  - Each cycle: `acc` ← `acc` | (`success_i` & mask). Success bits outside the mask are ignored.
  - Done when (`acc` | (`success_i` & mask)) == mask. Done goes to RETIRE.
  - Timeout counter increments each BCAST cycle. At count == `TIMEOUT_CYCLES`−1 without done: pulse `err_timeout_o` and go to RETIRE.
  - Done takes precedence over timeout in the same cycle.
- RETIRE: clear `acc` and the counter, return to IDLE. Outputs are idle.
- Outside BCAST, `channel_o` is all zeros. Outside REQ, `src_req_o` is 0.

## Timing
- Reset (synchronous, 1 cycle):
  - FSM goes to IDLE; queue emptied; `acc`, counter, `data_q` and `cur` are cleared.
  - Outputs: `instr_ready_o`=1, `src_req_o`=0, `src_addr_o`=0, `channel_o`=0, `busy_o`=0, `err_timeout_o`=0.
  - Reset mid-transfer abandons the order; no error pulse.
- Best-case latency for an order pushed at cycle t into an empty, idle block:
  - t+1: IDLE pops the order.
  - t+2: REQ; `src_req_o` high.
  - t+2: `src_valid` high in this cycle → t+3 BCAST.
  - t+3: all successes arrive → t+4 RETIRE.
  - t+5: IDLE, next pop possible.
- Throughput: one order per 4 cycles minimum.
- `err_timeout_o` is high for exactly the last BCAST cycle of a timed-out order.
- Push while full is refused. Push and pop in the same cycle when not full keeps the count.

## Test plan
- Reset with `instr_valid_i`=1 → after reset: `instr_ready_o`=1, `channel_o`=0, `busy_o`=0; nothing is enqueued during reset.
- Order euidx=1, mask=eus[2]|eus[3]; `src_valid_i[1]` at t+2 with data 0xA5; `success_i`=eus[2]|eus[3] at t+3 → `src_req_o`=0b0010 at t+2; `channel_o.data`=0xA5 at t+3; RETIRE at t+4.
- Same order, with eus[2] success at BCAST cycle 1 and eus[3] at cycle 4 → `success_list` shows eus[2] from cycle 2; retire after cycle 4; no error.
- Push 5 orders back-to-back with `FIFO_DEPTH`=4 while the first stalls in REQ → the 5th is refused (`instr_ready_o`=0). Orders complete in FIFO order and the pointers wrap correctly.
- `TIMEOUT_CYCLES`=8; the receiver never succeeds → `err_timeout_o` pulses in BCAST cycle 8; the next order starts.
- Mask=0 order followed by a valid order → the first is dropped with no `src_req_o`; the second is served normally. Also: reset asserted in BCAST → IDLE next cycle with no error pulse.
